sequenced_decoder: RTL and testbench
====================================

// Module: sequenced_decoder
// PURPOSE
//   Registered, parametrised ADDR_WIDTH-to-2^ADDR_WIDTH one-hot decoder; the
//   clocked successor to the 2-to-4 enable decoder.
//   Two modes: DIRECT decodes addresses accepted over a valid/ready handshake.
//   SCAN walks the one-hot select through every output, holding each for
//   SCAN_DWELL cycles.
//   Drives register-file/mux select lines and round-robin strobes.
// PARAMETERS
//   ADDR_WIDTH  2  address width; outputs NOUT = 1<<ADDR_WIDTH (localparam)
//   SCAN_DWELL  4  cycles each output stays active in SCAN mode; must be >= 1
// PORTS
//   clk            in   1           rising-edge clock
//   reset_n        in   1           asynchronous active-low reset
//   enable         in   1           global enable; low forces all outputs idle
//   mode           in   1           0 = DIRECT, 1 = SCAN
//   addr_valid     in   1           address offered (DIRECT mode)
//   address        in   ADDR_WIDTH  address to decode
//   addr_ready     out  1           address accepted on valid & ready
//   select         out  NOUT        registered one-hot select, or all zero
//   select_valid   out  1           select holds a live one-hot value
//   current_index  out  ADDR_WIDTH  binary index of active select bit; 0 when idle
//   scan_wrap      out  1           1-cycle pulse when SCAN wraps top -> bit 0
// BEHAVIOUR
//   Reset (reset_n low, async): state=IDLE; dwell counter=0.
//     select=0, select_valid=0, current_index=0, scan_wrap=0, addr_ready=0.
//   Invariant: select is exactly one-hot when select_valid=1, otherwise zero.
//   addr_ready = reset_n & enable & ~mode & (state != SCAN) (combinational).
//   FSM states: IDLE, DIRECT, SCAN; all transitions on the rising edge of clk.
//     IDLE  : enable & ~mode & addr_valid -> DIRECT; enable & mode -> SCAN.
//     DIRECT: holds select until the next accept, which replaces it.
//             ~enable or mode -> IDLE, with select cleared.
//     SCAN  : ~enable or ~mode -> IDLE, with select cleared.
//   DIRECT accept (addr_valid & addr_ready at an edge), 1-cycle latency:
//     select = 1<<address, current_index = address, select_valid = 1.
//     Back-to-back accepts: one new decode per cycle; no bubbles.
//     addr_valid with addr_ready=0: address ignored, not queued.
//   SCAN entry (edge leaving IDLE):
//     select=1 (bit 0), current_index=0, select_valid=1, dwell counter=0.
//   SCAN dwell: counter width $clog2(SCAN_DWELL)+1. It increments each cycle.
//     When counter == SCAN_DWELL-1: counter -> 0, select rotates left 1 bit,
//     current_index +1.
//     SCAN_DWELL=1 advances every cycle.
//   SCAN wrap: advancing from bit NOUT-1 returns to bit 0.
//     current_index wraps to 0; scan_wrap=1 that cycle only.
//   Leaving SCAN discards progress; re-entry restarts at bit 0 with dwell=0.
//   mode toggles with addr_valid high at the same edge: the mode change wins;
//     no accept.
//   enable low dominates mode and addr_valid: next edge -> IDLE, outputs zero.
//   Reset mid-operation: outputs zero immediately (async).
//     First edge after release behaves as from IDLE.
// TESTING
//   1 Reset: hold reset_n=0, toggle all inputs
//     -> select=0, select_valid=0, addr_ready=0 throughout.
//   2 DIRECT (ADDR_WIDTH=2): address=2, valid 1 cycle
//     -> next cycle select=4'b0100, current_index=2, select_valid=1; held.
//   3 Back-to-back: addresses 0,3,1 on consecutive cycles
//     -> select 0001,1000,0010 on consecutive cycles.
//     Then enable=0 -> select=0 next cycle.
//   4 SCAN (DWELL=4): mode=1 -> select 0001 x4, 0010 x4, 0100 x4, 1000 x4,
//     then 0001 with scan_wrap=1 for exactly that cycle.
//   5 Mode switch mid-SCAN at select=0100 -> select=0 next cycle, addr_ready=1.
//     Re-entering SCAN restarts at 0001.
//   6 ADDR_WIDTH=3, DWELL=1: full scan of 8 outputs, 1 per cycle, wrap pulse
//     every 8 cycles. Async reset mid-scan clears select without a clk edge.

Source files
------------

// File: rtl/sequenced_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : sequenced_decoder
//  Description : Registered ADDR_WIDTH-to-2^ADDR_WIDTH one-hot decoder.
//                DIRECT mode decodes addresses accepted over valid/ready.
//                SCAN mode walks the one-hot select across every output,
//                holding each for SCAN_DWELL cycles, pulsing scan_wrap on wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module sequenced_decoder #(
    parameter int ADDR_WIDTH = 2,
    parameter int SCAN_DWELL = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic                         mode,
    input  logic                         addr_valid,
    input  logic [ADDR_WIDTH-1:0]        address,
    output logic                         addr_ready,
    output logic [(1<<ADDR_WIDTH)-1:0]   select,
    output logic                         select_valid,
    output logic [ADDR_WIDTH-1:0]        current_index,
    output logic                         scan_wrap
);

    localparam int C_NOUT  = 1 << ADDR_WIDTH;
    localparam int C_CNT_W = $clog2(SCAN_DWELL) + 1;
    localparam logic [C_CNT_W-1:0] C_DWELL_LAST = C_CNT_W'(SCAN_DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t               r_state;
    logic [C_NOUT-1:0]    r_select;
    logic [ADDR_WIDTH-1:0] r_index;
    logic                 r_valid;
    logic                 r_wrap;
    logic [C_CNT_W-1:0]   r_dwell;

    state_t               w_state_nxt;
    logic [C_NOUT-1:0]    w_select_nxt;
    logic [ADDR_WIDTH-1:0] w_index_nxt;
    logic                 w_valid_nxt;
    logic                 w_wrap_nxt;
    logic [C_CNT_W-1:0]   w_dwell_nxt;
    logic [C_NOUT-1:0]    w_onehot;
    logic                 w_accept;

    // Ready is combinational so an address can be taken on the very edge
    // that enters DIRECT; SCAN never accepts.
    assign addr_ready = reset_n & enable & ~mode & (r_state != ST_SCAN);
    assign w_accept   = addr_valid & addr_ready;

    // One-hot image of the offered address.
    always_comb begin
        w_onehot          = '0;
        w_onehot[address] = 1'b1;
    end

    // Next-state and next-output logic; every path that lands in IDLE clears
    // the outputs so select is never stale.
    always_comb begin
        w_state_nxt  = r_state;
        w_select_nxt = r_select;
        w_index_nxt  = r_index;
        w_valid_nxt  = r_valid;
        w_wrap_nxt   = 1'b0;
        w_dwell_nxt  = r_dwell;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = ST_DIRECT;
                    w_select_nxt = w_onehot;
                    w_index_nxt  = address;
                    w_valid_nxt  = 1'b1;
                end else if (enable && mode) begin
                    w_state_nxt  = ST_SCAN;
                    w_select_nxt = C_NOUT'(1);
                    w_index_nxt  = '0;
                    w_valid_nxt  = 1'b1;
                    w_dwell_nxt  = '0;
                end
            end

            ST_DIRECT: begin
                if (!enable || mode) begin
                    w_state_nxt  = ST_IDLE;
                    w_select_nxt = '0;
                    w_index_nxt  = '0;
                    w_valid_nxt  = 1'b0;
                end else if (w_accept) begin
                    w_select_nxt = w_onehot;
                    w_index_nxt  = address;
                end
            end

            ST_SCAN: begin
                if (!enable || !mode) begin
                    w_state_nxt  = ST_IDLE;
                    w_select_nxt = '0;
                    w_index_nxt  = '0;
                    w_valid_nxt  = 1'b0;
                    w_dwell_nxt  = '0;
                end else if (r_dwell == C_DWELL_LAST) begin
                    // Dwell expired: rotate to the next output, wrapping top -> bit 0.
                    w_dwell_nxt  = '0;
                    w_select_nxt = {r_select[C_NOUT-2:0], r_select[C_NOUT-1]};
                    w_index_nxt  = r_index + ADDR_WIDTH'(1);
                    w_wrap_nxt   = r_select[C_NOUT-1];
                end else begin
                    w_dwell_nxt  = r_dwell + C_CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_select_nxt = '0;
                w_index_nxt  = '0;
                w_valid_nxt  = 1'b0;
                w_dwell_nxt  = '0;
            end
        endcase
    end

    // State and output registers; asynchronous reset clears everything at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_select <= '0;
            r_index  <= '0;
            r_valid  <= 1'b0;
            r_wrap   <= 1'b0;
            r_dwell  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_select <= w_select_nxt;
            r_index  <= w_index_nxt;
            r_valid  <= w_valid_nxt;
            r_wrap   <= w_wrap_nxt;
            r_dwell  <= w_dwell_nxt;
        end
    end

    assign select        = r_select;
    assign select_valid  = r_valid;
    assign current_index = r_index;
    assign scan_wrap     = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_sequenced_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sequenced_decoder
//  Description : Self-checking bench for sequenced_decoder. Two instances:
//                A (ADDR_WIDTH=2, SCAN_DWELL=4) and B (ADDR_WIDTH=3,
//                SCAN_DWELL=1), both checked against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sequenced_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       mode;
    logic       addr_valid;
    logic [1:0] address_a;
    logic [2:0] address_b;

    logic       addr_ready_a, select_valid_a, scan_wrap_a;
    logic [3:0] select_a;
    logic [1:0] current_index_a;
    logic       addr_ready_b, select_valid_b, scan_wrap_b;
    logic [7:0] select_b;
    logic [2:0] current_index_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: 0 = idle, 1 = direct, 2 = scan; t counts cycles spent in SCAN.
    int m_st   [2];
    int m_addr [2];
    int m_t    [2];
    logic [1:0] obs_rdy;
    logic [1:0] exp_rdy;

    sequenced_decoder #(.ADDR_WIDTH(2), .SCAN_DWELL(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
        .addr_valid(addr_valid), .address(address_a),
        .addr_ready(addr_ready_a), .select(select_a),
        .select_valid(select_valid_a), .current_index(current_index_a),
        .scan_wrap(scan_wrap_a)
    );

    sequenced_decoder #(.ADDR_WIDTH(3), .SCAN_DWELL(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
        .addr_valid(addr_valid), .address(address_b),
        .addr_ready(addr_ready_b), .select(select_b),
        .select_valid(select_valid_b), .current_index(current_index_b),
        .scan_wrap(scan_wrap_b)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_addr[k] = 0; m_t[k] = 0;
        end
    endfunction

    function automatic logic model_ready(int k, logic en, logic md);
        return reset_n && en && !md && (m_st[k] != 2);
    endfunction

    function automatic void model_step(int k, logic en, logic md, logic av, int ad);
        case (m_st[k])
            0: begin
                if (en && !md && av) begin m_st[k] = 1; m_addr[k] = ad; end
                else if (en && md) begin m_st[k] = 2; m_t[k] = 0; end
            end
            1: begin
                if (!en || md) m_st[k] = 0;
                else if (av)   m_addr[k] = ad;
            end
            default: begin
                if (!en || !md) m_st[k] = 0;
                else            m_t[k]++;
            end
        endcase
    endfunction

    // Expected {valid, wrap, index, select} packed as [12],[11],[10:8],[7:0].
    function automatic logic [15:0] exp_vec(int k, int d, int n);
        logic [15:0] v;
        int p;
        v = '0;
        if (m_st[k] == 1) begin
            v[7:0]  = 8'(1 << m_addr[k]);
            v[10:8] = 3'(m_addr[k]);
            v[12]   = 1'b1;
        end else if (m_st[k] == 2) begin
            p       = (m_t[k] / d) % n;
            v[7:0]  = 8'(1 << p);
            v[10:8] = 3'(p);
            v[12]   = 1'b1;
            v[11]   = (m_t[k] > 0) && ((m_t[k] % (d * n)) == 0);
        end
        return v;
    endfunction

    function automatic logic [15:0] obs_a();
        return {3'b0, select_valid_a, scan_wrap_a, 1'b0, current_index_a, 4'b0, select_a};
    endfunction

    function automatic logic [15:0] obs_b();
        return {3'b0, select_valid_b, scan_wrap_b, current_index_b, select_b};
    endfunction

    // Drive one cycle of inputs, record ready before the edge, advance model.
    task automatic tick(input logic en, input logic md, input logic av,
                        input logic [1:0] aa, input logic [2:0] ab);
        enable = en; mode = md; addr_valid = av; address_a = aa; address_b = ab;
        #1;
        obs_rdy = {addr_ready_b, addr_ready_a};
        exp_rdy = {model_ready(1, en, md), model_ready(0, en, md)};
        @(posedge clk);
        if (reset_n) begin
            model_step(0, en, md, av && exp_rdy[0], int'(aa));
            model_step(1, en, md, av && exp_rdy[1], int'(ab));
        end else begin
            model_reset();
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            tick(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom));
            n_tests++;
            if ({select_a, select_valid_a, select_b, select_valid_b, obs_rdy} !== 15'b0) begin
                n_fail++;
                $display("FAIL reset_hold: sel_a=%b v_a=%b sel_b=%b v_b=%b rdy=%b, required all 0",
                         select_a, select_valid_a, select_b, select_valid_b, obs_rdy);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_direct();
        tick(1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
        tick(1'b1, 1'b0, 1'b1, 2'd2, 3'd5);
        n_tests++;
        if (select_a !== 4'b0100 || current_index_a !== 2'd2 || select_valid_a !== 1'b1) begin
            n_fail++;
            $display("FAIL direct_a: sel=%b idx=%0d v=%b, required 0100 2 1",
                     select_a, current_index_a, select_valid_a);
        end
        n_tests++;
        if (select_b !== 8'b0010_0000 || current_index_b !== 3'd5) begin
            n_fail++;
            $display("FAIL direct_b: sel=%b idx=%0d, required 00100000 5", select_b, current_index_b);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b0, 2'($urandom), 3'($urandom));
            n_tests++;
            if (select_a !== 4'b0100 || select_b !== 8'b0010_0000) begin
                n_fail++;
                $display("FAIL direct_hold: sel_a=%b sel_b=%b, required 0100 00100000", select_a, select_b);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] addrs [3];
        logic [3:0] want  [3];
        addrs = '{2'd0, 2'd3, 2'd1};
        want  = '{4'b0001, 4'b1000, 4'b0010};
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b1, addrs[i], 3'(7 - i));
            n_tests++;
            if (select_a !== want[i] || obs_rdy[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_%0d: sel=%b rdy=%b, required %b 1", i, select_a, obs_rdy[0], want[i]);
            end
            n_tests++;
            if (obs_b() !== exp_vec(1, 1, 8)) begin
                n_fail++;
                $display("FAIL b2b_b_%0d: got %h, required %h", i, obs_b(), exp_vec(1, 1, 8));
            end
        end
        tick(1'b0, 1'b0, 1'b1, 2'd2, 3'd2);
        n_tests++;
        if (select_a !== 4'b0 || select_valid_a !== 1'b0 || select_b !== 8'b0) begin
            n_fail++;
            $display("FAIL b2b_disable: sel_a=%b v_a=%b sel_b=%b, required 0 0 0",
                     select_a, select_valid_a, select_b);
        end
    endtask

    task automatic test_scan();
        int wraps_a = 0;
        int wraps_b = 0;
        for (int i = 0; i < 17; i++) begin
            tick(1'b1, 1'b1, 1'($urandom), 2'($urandom), 3'($urandom));
            n_tests++;
            if (obs_a() !== exp_vec(0, 4, 4) || obs_b() !== exp_vec(1, 1, 8)) begin
                n_fail++;
                $display("FAIL scan_%0d: a=%h b=%h, required a=%h b=%h",
                         i, obs_a(), obs_b(), exp_vec(0, 4, 4), exp_vec(1, 1, 8));
            end
            wraps_a += int'(scan_wrap_a);
            wraps_b += int'(scan_wrap_b);
        end
        n_tests++;
        if (select_a !== 4'b0001 || scan_wrap_a !== 1'b1 || wraps_a != 1) begin
            n_fail++;
            $display("FAIL scan_wrap_a: sel=%b wrap=%b count=%0d, required 0001 1 1",
                     select_a, scan_wrap_a, wraps_a);
        end
        n_tests++;
        if (wraps_b != 2) begin
            n_fail++;
            $display("FAIL scan_wrap_b: count=%0d, required 2", wraps_b);
        end
        tick(1'b1, 1'b1, 1'b0, 2'd0, 3'd0);
        n_tests++;
        if (scan_wrap_a !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_wrap_pulse: wrap=%b, required 0", scan_wrap_a);
        end
    endtask

    task automatic test_mode_switch();
        tick(1'b1, 1'b0, 1'b0, 2'd0, 3'd0);
        for (int i = 0; i < 9; i++) tick(1'b1, 1'b1, 1'b0, 2'd0, 3'd0);
        n_tests++;
        if (select_a !== 4'b0100) begin
            n_fail++;
            $display("FAIL switch_setup: sel=%b, required 0100", select_a);
        end
        tick(1'b1, 1'b0, 1'b1, 2'd3, 3'd3);
        n_tests++;
        if (select_a !== 4'b0 || select_valid_a !== 1'b0 || obs_rdy !== 2'b00) begin
            n_fail++;
            $display("FAIL switch_exit: sel=%b v=%b rdy_pre=%b, required 0000 0 00",
                     select_a, select_valid_a, obs_rdy);
        end
        n_tests++;
        if (addr_ready_a !== 1'b1 || addr_ready_b !== 1'b1) begin
            n_fail++;
            $display("FAIL switch_ready: a=%b b=%b, required 1 1", addr_ready_a, addr_ready_b);
        end
        tick(1'b1, 1'b1, 1'b0, 2'd0, 3'd0);
        n_tests++;
        if (select_a !== 4'b0001 || select_b !== 8'b1 || current_index_a !== 2'd0) begin
            n_fail++;
            $display("FAIL switch_reentry: sel_a=%b sel_b=%b idx=%0d, required 0001 00000001 0",
                     select_a, select_b, current_index_a);
        end
    endtask

    task automatic test_random();
        logic md = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) md = ~md;
            tick(($urandom_range(0, 7) != 0), md, 1'($urandom), 2'($urandom), 3'($urandom));
            n_tests++;
            if (obs_a() !== exp_vec(0, 4, 4) || obs_b() !== exp_vec(1, 1, 8) || obs_rdy !== exp_rdy) begin
                n_fail++;
                $display("FAIL random_%0d: a=%h b=%h rdy=%b, required a=%h b=%h rdy=%b",
                         i, obs_a(), obs_b(), obs_rdy, exp_vec(0, 4, 4), exp_vec(1, 1, 8), exp_rdy);
            end
        end
    endtask

    task automatic test_async_reset();
        tick(1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 2'd0, 3'd0);
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (select_a !== 4'b0 || select_b !== 8'b0 || select_valid_b !== 1'b0 ||
            addr_ready_a !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: sel_a=%b sel_b=%b v_b=%b rdy=%b, required 0 0 0 0",
                     select_a, select_b, select_valid_b, addr_ready_a);
        end
        tick(1'b1, 1'b1, 1'b0, 2'd0, 3'd0);
        reset_n = 1'b1;
        tick(1'b1, 1'b1, 1'b0, 2'd0, 3'd0);
        n_tests++;
        if (select_a !== 4'b0001 || select_b !== 8'b1 || scan_wrap_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: sel_a=%b sel_b=%b wrap=%b, required 0001 00000001 0",
                     select_a, select_b, scan_wrap_b);
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; mode = 1'b0; addr_valid = 1'b0;
        address_a = '0; address_b = '0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_direct();
        test_back_to_back();
        test_scan();
        test_mode_switch();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
